// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - md_op_e    : 4-bit operation codes driven by decode
//   - md_class_e : execution class of an op (mul, div, move, none)
//   - md_state_e : unit state (IDLE / RUN)
//   - op_class() : maps a raw op code onto its class; undefined codes -> CLS_NONE
package md_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10
    } md_op_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_MUL,
        CLS_DIV,
        CLS_MOVE
    } md_class_e;

    typedef enum logic {
        IDLE,
        RUN
    } md_state_e;

    function automatic md_class_e op_class(input logic [3:0] op);
        md_class_e cls;
        cls = CLS_NONE;
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU:              cls = CLS_MUL;
            OP_DIV, OP_DIVU:                cls = CLS_DIV;
            OP_MTHI, OP_MTLO:               cls = CLS_MOVE;
            default:                        cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/md_div.sv
// md_div: combinational divider for the HI/LO unit.
//   a, b      : dividend / divisor (latched operands)
//   is_signed : 1 for DIV, 0 for DIVU
//   quo       : quotient, truncated toward zero
//   rem       : remainder, sign follows the dividend
// Divide-by-zero yields quo = all ones, rem = a. The signed overflow case
// (most-negative / -1) yields quo = a, rem = 0.
module md_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        quo = '0;
        rem = '0;
        if (b == '0) begin
            quo = '1;
            rem = a;
        end else if (is_signed && (a == MIN_NEG) && (b == '1)) begin
            quo = a;
            rem = '0;
        end else if (is_signed) begin
            quo = $signed(a) / $signed(b);
            rem = $signed(a) % $signed(b);
        end else begin
            quo = a / b;
            rem = a % b;
        end
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage HI/LO multiply/divide unit with multiply-accumulate,
// abort and completion pulse.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   start, op  : op valid / op code (md_pkg::md_op_e encoding)
//   a, b       : rs / rt operands, latched on accept
//   cancel     : abort the in-flight op; also drops a same-cycle start
//   busy       : op in flight (RUN state)
//   done       : one-cycle pulse when new HI/LO become visible
//   hi, lo     : HI / LO registers
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
    localparam int unsigned W2         = 2 * WIDTH;

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    md_op_e            op_q;
    logic [WIDTH-1:0]  a_q, b_q;

    logic              latch_en;
    logic              complete;
    logic              move_hi;
    logic              move_lo;

    logic              mul_signed;
    logic [W2-1:0]     a_ext, b_ext, prod;
    logic [WIDTH-1:0]  div_quo, div_rem;
    logic [W2-1:0]     result;

    // Next-state / control decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        complete = 1'b0;
        move_hi  = 1'b0;
        move_lo  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    case (op_class(op))
                        CLS_MUL: begin
                            state_d  = RUN;
                            cnt_d    = CW'(MUL_CYCLES);
                            latch_en = 1'b1;
                        end
                        CLS_DIV: begin
                            state_d  = RUN;
                            cnt_d    = CW'(DIV_CYCLES);
                            latch_en = 1'b1;
                        end
                        CLS_MOVE: begin
                            move_hi = (op == OP_MTHI);
                            move_lo = (op == OP_MTLO);
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // cancel takes priority even on the completion edge
                if (cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Datapath: works only from latched operands
    always_comb begin
        mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        a_ext = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod  = a_ext * b_ext;
    end

    md_div #(
        .WIDTH(WIDTH)
    ) u_div (
        .a         (a_q),
        .b         (b_q),
        .is_signed (op_q == OP_DIV),
        .quo       (div_quo),
        .rem       (div_rem)
    );

    always_comb begin
        result = '0;
        case (op_q)
            OP_MULT, OP_MULTU: result = prod;
            OP_MADD, OP_MADDU: result = {hi, lo} + prod;
            OP_MSUB, OP_MSUBU: result = {hi, lo} - prod;
            default:           result = {div_rem, div_quo};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done    <= complete;
            if (latch_en) begin
                op_q <= md_op_e'(op);
                a_q  <= a;
                b_q  <= b;
            end
            if (complete) begin
                hi <= result[W2-1:WIDTH];
                lo <= result[WIDTH-1:0];
            end else begin
                if (move_hi) hi <= a;
                if (move_lo) lo <= a;
            end
        end
    end

    assign busy = (state_q == RUN);

endmodule
